led_matrix_scan_ctrl: RTL and testbench

Parametrised successor row-scan controller for the HUB75-style LED panel.
- Drives row address, blank and latch.
- Requests each (row, bit-plane) line from the line shifter one step ahead, so shifting overlaps display.
- Adds binary-coded modulation: plane k is lit BASE_ON<<k cycles, timed exactly regardless of shifter latency.
- Adds a run/park enable and a frame-start marker; sits between the framebuffer line shifter and the panel pins.

---
 rtl/led_matrix_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_ctrl.sv
// HUB75-style row-scan controller with binary-coded modulation.
// Walks (row, plane) items in order. Each item is requested from the line
// shifter one step ahead, so the next line shifts while the current one is lit.
// Plane k stays lit for exactly BASE_ON<<k cycles. That time never stretches:
// if the next line is late, the panel is blanked and the controller waits.
module led_matrix_scan_ctrl #(
    parameter int ROWS        = 20,
    parameter int ROW_W       = 5,
    parameter int PWM_BITS    = 7,
    parameter int PLANE_W     = 3,
    parameter int BASE_ON     = 16,
    parameter int LATCH_W     = 2,
    parameter int BLANK_GUARD = 2
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic               enable,
    output logic [ROW_W-1:0]   row_addr,
    output logic               blank,
    output logic               latch,
    output logic               next_line_begin,
    input  logic               next_line_done,
    output logic [ROW_W-1:0]   next_line_addr,
    output logic [PLANE_W-1:0] next_line_plane,
    output logic               frame_start
);

    // The timer holds the longest lit time, BASE_ON<<(PWM_BITS-1), without wrapping.
    localparam int TIMER_W = $clog2(BASE_ON << (PWM_BITS - 1)) + 1;

    // One down-counter is shared by the guard phases and the latch phase.
    localparam int CNT_MAX = (LATCH_W > BLANK_GUARD) ? LATCH_W : BLANK_GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PWM_BITS - 1);
    localparam logic [CNT_W-1:0]   LATCH_LOAD = CNT_W'(LATCH_W - 1);
    localparam logic [CNT_W-1:0]   GUARD_LOAD = CNT_W'(BLANK_GUARD - 1);
    localparam logic [TIMER_W-1:0] BASE_T     = TIMER_W'(BASE_ON);

    // Scan states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIME   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SWITCH  = 3'd4;
    localparam logic [2:0] S_UNBLANK = 3'd5;
    localparam logic [2:0] S_DISPLAY = 3'd6;

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [TIMER_W-1:0] timer;
    logic [PLANE_W-1:0] shown_plane;

    // Shifter handshake bookkeeping
    logic done_flag;
    logic line_busy;

    logic               issue_req;
    logic               done_ready;
    logic               line_pending;
    logic               latch_last;
    logic [ROW_W-1:0]   succ_addr;
    logic [PLANE_W-1:0] succ_plane;

    // Find the item that follows the one now held in next_line_addr/next_line_plane.
    // The row wraps at ROWS-1, not at the top of the address range.
    always_comb begin
        succ_addr  = next_line_addr;
        succ_plane = next_line_plane + PLANE_W'(1);
        if (next_line_plane == LAST_PLANE) begin
            succ_plane = '0;
            succ_addr  = (next_line_addr == LAST_ROW) ? '0 : next_line_addr + ROW_W'(1);
        end
    end

    // Decide when to request a line.
    // The controller requests a line when it leaves IDLE, or on the last latch
    // cycle while scanning is enabled.
    // A done pulse that arrives during the begin cycle belongs to no current
    // request and is not treated as ready.
    always_comb begin
        issue_req = 1'b0;
        case (state)
            S_IDLE:  issue_req = enable && !line_busy;
            S_LATCH: issue_req = (cnt == '0) && enable;
            default: issue_req = 1'b0;
        endcase
        latch_last   = (state == S_LATCH) && (cnt == '0);
        done_ready   = !next_line_begin && (done_flag || (next_line_done && line_busy));
        line_pending = done_flag || line_busy;
    end

    // Track the shifter handshake.
    // line_busy marks an outstanding request.
    // done_flag remembers a finished line until the latch consumes it.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            next_line_begin <= 1'b0;
            line_busy       <= 1'b0;
            done_flag       <= 1'b0;
        end else begin
            next_line_begin <= issue_req;
            if (issue_req) begin
                line_busy <= 1'b1;
            end else if (next_line_done && !next_line_begin) begin
                line_busy <= 1'b0;
            end
            if (next_line_begin || latch_last) begin
                done_flag <= 1'b0;
            end else if (next_line_done && line_busy) begin
                done_flag <= 1'b1;
            end
        end
    end

    // Main scan sequencer.
    // Order: blank guard, latch, switch guard, then a lit phase of fixed length.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            timer           <= '0;
            row_addr        <= '0;
            shown_plane     <= '0;
            next_line_addr  <= '0;
            next_line_plane <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_req) begin
                        next_line_addr  <= '0;
                        next_line_plane <= '0;
                        state           <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (done_ready) begin
                        cnt   <= GUARD_LOAD;
                        state <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (cnt == '0) begin
                        cnt   <= LATCH_LOAD;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (cnt == '0) begin
                        // The shifted line becomes the shown line.
                        // The request pointer moves on to the next item.
                        row_addr        <= next_line_addr;
                        shown_plane     <= next_line_plane;
                        next_line_addr  <= succ_addr;
                        next_line_plane <= succ_plane;
                        cnt             <= GUARD_LOAD;
                        state           <= S_SWITCH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SWITCH: begin
                    if (cnt == '0) begin
                        // The lit time counts the UNBLANK cycle.
                        // So the timer is loaded here and runs down from UNBLANK on.
                        timer <= BASE_T << shown_plane;
                        state <= S_UNBLANK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_UNBLANK: begin
                    timer <= timer - TIMER_W'(1);
                    state <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    if (timer != '0) begin
                        timer <= timer - TIMER_W'(1);
                    end else if (!enable || !line_pending) begin
                        // Park now: drop any prefetched line and restart from (0,0).
                        state <= S_IDLE;
                    end else if (done_ready) begin
                        cnt   <= GUARD_LOAD;
                        state <= S_BLANK;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decode the panel controls from the state.
    // Reset forces IDLE, so these outputs go to their off levels at once.
    assign latch       = (state == S_LATCH);
    assign blank       = !((state == S_UNBLANK) || ((state == S_DISPLAY) && (timer != '0)));
    assign frame_start = (state == S_UNBLANK) && (row_addr == '0) && (shown_plane == '0);

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl.
// The small instance (a_*) uses 3 rows, 2 planes and BASE_ON 4, and runs the directed and randomized scenarios.
// The default instance (b_*) scans one full frame to check the row wrap and the long planes.
module tb_led_matrix_scan_ctrl;

    localparam int A_ROWS = 3;
    localparam int A_PB   = 2;
    localparam int A_BASE = 4;
    localparam int A_LW   = 2;
    localparam int A_BG   = 2;
    localparam int B_ROWS = 20;
    localparam int B_PB   = 7;
    localparam int B_BASE = 16;
    localparam int B_LAT  = 40;

    logic clk_25MHz;
    logic rst_n, enable;
    logic [1:0] row_addr, next_line_addr;
    logic [0:0] next_line_plane;
    logic blank, latch, next_line_begin, next_line_done, frame_start;

    logic rst_n_b, enable_b;
    logic [4:0] b_row_addr, b_next_addr;
    logic [2:0] b_next_plane;
    logic b_blank, b_latch, b_begin, b_done, b_frame;

    int checks = 0;
    int passes = 0;

    led_matrix_scan_ctrl #(
        .ROWS(A_ROWS), .ROW_W(2), .PWM_BITS(A_PB), .PLANE_W(1),
        .BASE_ON(A_BASE), .LATCH_W(A_LW), .BLANK_GUARD(A_BG)
    ) dut_a (
        .clk_25MHz(clk_25MHz), .rst_n(rst_n), .enable(enable),
        .row_addr(row_addr), .blank(blank), .latch(latch),
        .next_line_begin(next_line_begin), .next_line_done(next_line_done),
        .next_line_addr(next_line_addr), .next_line_plane(next_line_plane),
        .frame_start(frame_start)
    );

    led_matrix_scan_ctrl dut_b (
        .clk_25MHz(clk_25MHz), .rst_n(rst_n_b), .enable(enable_b),
        .row_addr(b_row_addr), .blank(b_blank), .latch(b_latch),
        .next_line_begin(b_begin), .next_line_done(b_done),
        .next_line_addr(b_next_addr), .next_line_plane(b_next_plane),
        .frame_start(b_frame)
    );

    // 25 MHz clock
    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    endtask

    // Scan order as arithmetic on the item index n
    function automatic int item_row(input int n, input int pb, input int rows);
        return (n / pb) % rows;
    endfunction
    function automatic int item_plane(input int n, input int pb);
        return n % pb;
    endfunction

    // Shifter model A.
    // Fixed or random latency. It can also answer only in the begin cycle (glitch) or give one manual pulse.
    int a_lat = 3;
    bit a_random = 0, a_glitch = 0, a_glitch_used = 0, a_manual = 0;
    int a_cnt;
    bit a_pend;
    initial begin
        next_line_done = 1'b0;
        a_pend = 0;
        a_cnt = 0;
        forever begin
            @(posedge clk_25MHz); #1;
            next_line_done = 1'b0;
            if (!rst_n) a_pend = 0;
            else if (next_line_begin) begin
                if (a_glitch) begin
                    next_line_done = 1'b1; a_glitch = 0; a_glitch_used = 1; a_pend = 0;
                end else begin
                    a_pend = 1;
                    a_cnt = a_random ? int'($urandom_range(1, 25)) : a_lat;
                end
            end else if (a_manual) begin
                next_line_done = 1'b1; a_manual = 0;
            end else if (a_pend) begin
                a_cnt--;
                if (a_cnt == 0) begin next_line_done = 1'b1; a_pend = 0; end
            end
        end
    end

    // Shifter model B: fixed latency
    int b_cnt;
    bit b_pend;
    initial begin
        b_done = 1'b0;
        b_pend = 0;
        b_cnt = 0;
        forever begin
            @(posedge clk_25MHz); #1;
            b_done = 1'b0;
            if (!rst_n_b) b_pend = 0;
            else if (b_begin) begin b_pend = 1; b_cnt = B_LAT; end
            else if (b_pend) begin
                b_cnt--;
                if (b_cnt == 0) begin b_done = 1'b1; b_pend = 0; end
            end
        end
    end

    // Reference model and monitor for DUT A
    int a_q[$];
    int a_nreq, a_credits, a_latch_len, a_lit_len, a_idx;
    int a_shown_row, a_shown_plane;
    int a_latches = 0, a_fs_total = 0;
    logic a_blank_prev, a_latch_prev;
    initial begin
        forever begin
            @(negedge clk_25MHz);
            if (!rst_n) begin
                a_q.delete(); a_nreq = 0; a_credits = 0; a_latch_len = 0; a_lit_len = 0;
                a_shown_row = 0; a_shown_plane = 0; a_blank_prev = 1'b1; a_latch_prev = 1'b0;
            end else begin
                if (next_line_done && !next_line_begin) a_credits++;
                if (frame_start) a_fs_total++;
                if (next_line_begin) begin
                    checkOutput("a_req_row", next_line_addr, item_row(a_nreq, A_PB, A_ROWS));
                    checkOutput("a_req_plane", next_line_plane, item_plane(a_nreq, A_PB));
                    a_q.push_back(a_nreq);
                    a_nreq++;
                end
                if (latch && !a_latch_prev) begin
                    checkOutput("a_latch_after_done", a_credits > 0, 1);
                    checkOutput("a_blank_at_latch", blank, 1);
                    if (a_credits > 0) a_credits--;
                    a_latch_len = 1;
                end else if (latch) a_latch_len++;
                if (!latch && a_latch_prev) begin
                    checkOutput("a_latch_len", a_latch_len, A_LW);
                    checkOutput("a_req_queued", a_q.size() > 0, 1);
                    if (a_q.size() > 0) begin
                        a_idx = a_q.pop_front();
                        a_shown_row = item_row(a_idx, A_PB, A_ROWS);
                        a_shown_plane = item_plane(a_idx, A_PB);
                    end
                    checkOutput("a_row_addr", row_addr, a_shown_row);
                    a_latches++;
                end
                if (!blank && a_blank_prev) begin
                    checkOutput("a_frame_start", frame_start, (a_shown_row == 0 && a_shown_plane == 0));
                    a_lit_len = 1;
                end else if (!blank) a_lit_len++;
                if (blank && !a_blank_prev && a_lit_len > 0) begin
                    checkOutput("a_lit_len", a_lit_len, A_BASE << a_shown_plane);
                    a_lit_len = 0;
                end
                a_blank_prev = blank;
                a_latch_prev = latch;
            end
        end
    end

    // Reference model and monitor for DUT B (default parameters)
    int b_q[$];
    int b_nreq, b_lit, b_shown_plane;
    int b_p6_runs = 0, b_fs = 0, b_fs_at_wrap = 0;
    bit b_wrap_seen = 0;
    logic b_blank_prev, b_latch_prev;
    initial begin
        forever begin
            @(negedge clk_25MHz);
            if (!rst_n_b) begin
                b_q.delete(); b_nreq = 0; b_lit = 0; b_shown_plane = 0;
                b_blank_prev = 1'b1; b_latch_prev = 1'b0;
            end else begin
                if (b_frame) b_fs++;
                if (b_begin) begin
                    checkOutput("b_req_row", b_next_addr, item_row(b_nreq, B_PB, B_ROWS));
                    checkOutput("b_req_plane", b_next_plane, item_plane(b_nreq, B_PB));
                    if (b_nreq == B_ROWS * B_PB) begin b_wrap_seen = 1; b_fs_at_wrap = b_fs; end
                    b_q.push_back(b_nreq);
                    b_nreq++;
                end
                if (!b_latch && b_latch_prev) begin
                    if (b_q.size() > 0) b_shown_plane = item_plane(b_q.pop_front(), B_PB);
                    checkOutput("b_row_range", b_row_addr < B_ROWS, 1);
                end
                if (!b_blank && b_blank_prev) b_lit = 1;
                else if (!b_blank) b_lit++;
                if (b_blank && !b_blank_prev && b_lit > 0) begin
                    checkOutput("b_lit_len", b_lit, B_BASE << b_shown_plane);
                    if (b_shown_plane == B_PB - 1) b_p6_runs++;
                    b_lit = 0;
                end
                b_blank_prev = b_blank;
                b_latch_prev = b_latch;
            end
        end
    end

    // Set enable, then let the given number of cycles pass
    task automatic applyStimulus(input logic en, input int cycles);
        enable = en;
        repeat (cycles) begin @(negedge clk_25MHz); #2; end
    endtask

    // Wait until DUT A has latched 'target' lines in total, within a cycle budget
    task automatic waitLatches(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (a_latches < target && n < budget) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput({tag, "_timeout"}, a_latches >= target, 1);
    endtask

    int n, lat0, nreq_drop;
    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0; enable = 1'b0; enable_b = 1'b0;
        repeat (3) @(posedge clk_25MHz);
        #1;
        checkOutput("rst_blank", blank, 1);
        checkOutput("rst_latch", latch, 0);
        checkOutput("rst_begin", next_line_begin, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_row_addr", row_addr, 0);
        checkOutput("rst_next_addr", next_line_addr, 0);
        checkOutput("rst_next_plane", next_line_plane, 0);
        checkOutput("rst_b_blank", b_blank, 1);
        @(negedge clk_25MHz); #2;
        rst_n = 1'b1; rst_n_b = 1'b1; enable_b = 1'b1;
        applyStimulus(1'b0, 5);
        checkOutput("park_blank", blank, 1);

        // Fast shifter: 12 planes make two frames
        a_lat = 3;
        applyStimulus(1'b1, 0);
        waitLatches("t1", 12, 2000);
        checkOutput("t1_frames", a_fs_total, 2);

        // Random shifter latency
        a_random = 1;
        waitLatches("rand", a_latches + 30, 6000);
        a_random = 0;

        // Slow shifter: lit time stays exact and no line is latched before its done
        a_lat = 20;
        waitLatches("t2", a_latches + 6, 1000);
        a_lat = 3;

        // A done that arrives only in the begin cycle must stall the scan
        a_glitch_used = 0;
        a_glitch = 1;
        n = 0;
        while (!a_glitch_used && n < 500) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput("t3_glitch_seen", a_glitch_used, 1);
        applyStimulus(1'b1, 80);
        lat0 = a_latches;
        applyStimulus(1'b1, 40);
        checkOutput("t3_stalled", a_latches, lat0);
        checkOutput("t3_blank", blank, 1);
        a_manual = 1;
        waitLatches("t3_resume", lat0 + 3, 500);

        // Drop enable while (1,1) is lit
        n = 0;
        while (!(a_shown_row == 1 && a_shown_plane == 1 && !blank) && n < 2000) begin
            @(negedge clk_25MHz); #2; n++;
        end
        checkOutput("t4_found_1_1", (a_shown_row == 1 && a_shown_plane == 1 && !blank), 1);
        nreq_drop = a_nreq;
        applyStimulus(1'b0, 40);
        checkOutput("t4_no_begin", a_nreq, nreq_drop);
        checkOutput("t4_blank", blank, 1);
        a_q.delete(); a_credits = 0; a_nreq = 0; a_fs_total = 0;
        enable = 1'b1;
        n = 0;
        while (a_fs_total == 0 && n < 200) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput("t4_restart_fs", a_fs_total, 1);
        checkOutput("t4_restart_row", a_shown_row, 0);
        checkOutput("t4_restart_plane", a_shown_plane, 0);

        // Reset in the middle of a latch
        n = 0;
        while (!latch && n < 200) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput("t5_latch_seen", latch, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t5_blank", blank, 1);
        checkOutput("t5_latch", latch, 0);
        checkOutput("t5_row_addr", row_addr, 0);
        checkOutput("t5_begin", next_line_begin, 0);
        @(negedge clk_25MHz); #2;
        @(negedge clk_25MHz); #2;
        rst_n = 1'b1;
        n = 0;
        while (!next_line_begin && n < 50) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput("t5_first_begin", next_line_begin, 1);
        checkOutput("t5_first_addr", next_line_addr, 0);
        checkOutput("t5_first_plane", next_line_plane, 0);
        waitLatches("t5_run", a_latches + 4, 500);

        // Default instance: a full frame, then the wrap back to (0,0)
        n = 0;
        while (!b_wrap_seen && n < 60000) begin @(negedge clk_25MHz); #2; n++; end
        checkOutput("b_wrap_seen", b_wrap_seen, 1);
        checkOutput("b_plane6_runs", b_p6_runs > 0, 1);
        checkOutput("b_one_frame_start", b_fs_at_wrap, 1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
